mix_char_out: RTL and testbench

- MIX character output unit: the device-side responder for the CPU's OUT operation.
- On a start pulse it reads a block of MIX words from main memory through a synchronous read port. It unpacks each word into five 6-bit MIX character codes and translates them to ASCII.
- The characters are serialized on a UART 8N1 transmit line, followed by CR LF. It models the MIX teletype (unit 19, 14-word blocks).
- Sits beside the core on the 4096x31 memory; busy feeds the core's JBUS/JRED tests.

---
 rtl/mix_char_out.sv | 235 +++++++++++++++++++++++
 tb/tb_mix_char_out.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_char_out.sv
// ---------------------------------------------------------------------------
// mix_char_out
// MIX character output unit (teletype, unit 19). On a start request it reads
// a block of MIX words from main memory, splits each word into five 6-bit
// MIX character codes, translates them to ASCII and sends them on a UART 8N1
// line. An optional CR LF follows each block.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-low reset
//   i_start      one-cycle print request, accepted only while idle
//   i_start_addr address of the first word of the block
//   o_mem_rd     one-cycle memory read strobe
//   o_mem_addr   read address, valid while o_mem_rd is high
//   i_mem_data   memory word, valid the cycle after o_mem_rd
//   o_tx         UART serial output, idle high
//   o_busy       high while a block is being printed
//   o_done       one-cycle pulse on the cycle o_busy falls
// ---------------------------------------------------------------------------
module mix_char_out #(
   parameter int BLOCK_WORDS  = 14,
   parameter int CLKS_PER_BIT = 434,
   parameter int EOL          = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [11:0] i_start_addr,
   output logic        o_mem_rd,
   output logic [11:0] o_mem_addr,
   input  logic [30:0] i_mem_data,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [3:0] {
      IDLE, READ, CAPTURE, LOAD, START, DATA, STOP, EOL_CR, EOL_LF
   } stateT;

   stateT       r_state;
   logic [CW-1:0] r_clkCnt;
   logic [2:0]  r_bitIdx;
   logic [2:0]  r_charIdx;
   logic [11:0] r_wordCnt;
   logic [29:0] r_wordReg;
   logic [7:0]  r_shift;
   logic [1:0]  r_eolPhase;
   logic        r_memRd;
   logic [11:0] r_memAddr;
   logic        r_tx;
   logic        r_busy;
   logic        r_done;

   logic [7:0]  w_char;
   logic        w_bitEnd;

   // MIX character code to ASCII; delta, sigma, pi and unassigned codes
   // print as '?'.
   function automatic logic [7:0] mixToAscii(input logic [5:0] code);
      logic [7:0] c8;
      logic [7:0] res;
      c8  = {2'b00, code};
      res = 8'h3F;
      if (code == 6'd0)
         res = 8'h20;
      else if (code <= 6'd9)
         res = c8 + 8'h40;
      else if (code >= 6'd11 && code <= 6'd19)
         res = c8 + 8'h3F;
      else if (code >= 6'd22 && code <= 6'd29)
         res = c8 + 8'h3D;
      else if (code >= 6'd30 && code <= 6'd39)
         res = c8 + 8'h12;
      else begin
         case (code)
            6'd40:   res = 8'h2E;
            6'd41:   res = 8'h2C;
            6'd42:   res = 8'h28;
            6'd43:   res = 8'h29;
            6'd44:   res = 8'h2B;
            6'd45:   res = 8'h2D;
            6'd46:   res = 8'h2A;
            6'd47:   res = 8'h2F;
            6'd48:   res = 8'h3D;
            6'd49:   res = 8'h24;
            6'd50:   res = 8'h3C;
            6'd51:   res = 8'h3E;
            6'd52:   res = 8'h40;
            6'd53:   res = 8'h3B;
            6'd54:   res = 8'h3A;
            6'd55:   res = 8'h27;
            default: res = 8'h3F;
         endcase
      end
      return res;
   endfunction

   // The word register is shifted left after each character, so the next
   // character code is always in its top six bits.
   assign w_char   = mixToAscii(r_wordReg[29:24]);
   assign w_bitEnd = (r_clkCnt == CW'(CLKS_PER_BIT - 1));

   // Sequencer: memory fetch, character unpacking and the UART bit timing
   // all live in this one block; every output is registered here.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_clkCnt   <= '0;
         r_bitIdx   <= '0;
         r_charIdx  <= '0;
         r_wordCnt  <= '0;
         r_wordReg  <= '0;
         r_shift    <= '0;
         r_eolPhase <= '0;
         r_memRd    <= 1'b0;
         r_memAddr  <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_memRd <= 1'b0;
         case (r_state)
            IDLE: begin
               // A start coinciding with the done pulse is dropped.
               if (i_start && !r_done) begin
                  r_memAddr  <= i_start_addr;
                  r_wordCnt  <= '0;
                  r_eolPhase <= '0;
                  r_busy     <= 1'b1;
                  r_memRd    <= 1'b1;
                  r_state    <= READ;
               end
            end
            READ: begin
               r_state <= CAPTURE;
            end
            CAPTURE: begin
               r_wordReg <= i_mem_data[29:0];
               r_charIdx <= '0;
               r_state   <= LOAD;
            end
            LOAD: begin
               r_shift    <= w_char;
               r_wordReg  <= {r_wordReg[23:0], 6'd0};
               r_eolPhase <= 2'd0;
               r_clkCnt   <= '0;
               r_tx       <= 1'b0;
               r_state    <= START;
            end
            EOL_CR: begin
               r_shift    <= 8'h0D;
               r_eolPhase <= 2'd1;
               r_clkCnt   <= '0;
               r_tx       <= 1'b0;
               r_state    <= START;
            end
            EOL_LF: begin
               r_shift    <= 8'h0A;
               r_eolPhase <= 2'd2;
               r_clkCnt   <= '0;
               r_tx       <= 1'b0;
               r_state    <= START;
            end
            START: begin
               if (w_bitEnd) begin
                  r_clkCnt <= '0;
                  r_bitIdx <= '0;
                  r_tx     <= r_shift[0];
                  r_shift  <= {1'b0, r_shift[7:1]};
                  r_state  <= DATA;
               end else begin
                  r_clkCnt <= r_clkCnt + 1'b1;
               end
            end
            DATA: begin
               if (w_bitEnd) begin
                  r_clkCnt <= '0;
                  if (r_bitIdx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bitIdx <= r_bitIdx + 1'b1;
                     r_tx     <= r_shift[0];
                     r_shift  <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + 1'b1;
               end
            end
            STOP: begin
               if (w_bitEnd) begin
                  r_clkCnt <= '0;
                  if (r_eolPhase == 2'd1) begin
                     r_state <= EOL_LF;
                  end else if (r_eolPhase == 2'd2) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else if (r_charIdx < 3'd4) begin
                     r_charIdx <= r_charIdx + 1'b1;
                     r_state   <= LOAD;
                  end else if (r_wordCnt < 12'(BLOCK_WORDS - 1)) begin
                     r_wordCnt <= r_wordCnt + 1'b1;
                     r_memAddr <= r_memAddr + 1'b1;
                     r_memRd   <= 1'b1;
                     r_state   <= READ;
                  end else if (EOL != 0) begin
                     r_state <= EOL_CR;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_clkCnt <= r_clkCnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_mem_rd   = r_memRd;
   assign o_mem_addr = r_memAddr;
   assign o_tx       = r_tx;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_mix_char_out.sv
// ---------------------------------------------------------------------------
// tb_mix_char_out
// Self-checking bench for mix_char_out. A memory model answers reads, a UART
// receiver decodes the serial line, and the expected character stream,
// frame spacing and busy length are derived from the MIX character table
// and the block timing rules.
// ---------------------------------------------------------------------------
module tb_mix_char_out;

   localparam int BW    = 3;
   localparam int CPB   = 4;
   localparam int EOLP  = 1;
   localparam int FRAME = 10 * CPB;
   localparam int LIMIT = 5000;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0;
   logic [11:0] startAddr = '0;
   logic        memRd;
   logic [11:0] memAddr;
   logic [30:0] memData = '0;
   logic        tx;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int cycleCnt = 0;
   int busyLen = 0;

   logic [30:0] mem [0:4095];
   int rdAddrQ[$];
   int rxByteQ[$];
   int rxTimeQ[$];

   // Index = MIX code, character = ASCII printed for it.
   string mixTable = " ABCDEFGHI?JKLMNOPQR??STUVWXYZ0123456789.,()+-*/=$<>@;:'????????";

   always #5 clk = ~clk;

   mix_char_out #(
      .BLOCK_WORDS (BW),
      .CLKS_PER_BIT(CPB),
      .EOL         (EOLP)
   ) dut (
      .i_clk       (clk),
      .i_reset     (resetN),
      .i_start     (start),
      .i_start_addr(startAddr),
      .o_mem_rd    (memRd),
      .o_mem_addr  (memAddr),
      .i_mem_data  (memData),
      .o_tx        (tx),
      .o_busy      (busy),
      .o_done      (done)
   );

   // Synchronous memory: data appears the cycle after the strobe, garbage
   // otherwise, and every read address is logged.
   always @(posedge clk) begin
      cycleCnt <= cycleCnt + 1;
      if (memRd === 1'b1) begin
         memData <= mem[memAddr];
         rdAddrQ.push_back(int'(memAddr));
      end else begin
         memData <= 31'($urandom);
      end
   end

   // UART receiver: samples each bit in its middle, logs {stop, byte} and
   // the cycle the start bit began.
   initial begin
      logic [7:0] b;
      int t0;
      forever begin
         @(negedge clk);
         if (resetN === 1'b1 && tx === 1'b0) begin
            t0 = cycleCnt;
            for (int i = 0; i < 8; i++) begin
               if (i == 0) repeat (CPB + CPB / 2) @(negedge clk);
               else        repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            rxByteQ.push_back(int'({tx, b}));
            rxTimeQ.push_back(t0);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic startBlock(input logic [11:0] addr);
      rdAddrQ.delete();
      rxByteQ.delete();
      rxTimeQ.delete();
      @(negedge clk);
      start     = 1'b1;
      startAddr = addr;
      @(negedge clk);
      start     = 1'b0;
      startAddr = 12'($urandom);
      checkOutput("busyAfterStart", 32'(busy), 32'd1);
      busyLen = 1;
   endtask

   // Waits (bounded) for done, counting busy cycles; optionally pulses a
   // competing start request lateStart cycles in.
   task automatic waitDone(input int lateStart, input logic [11:0] lateAddr);
      for (int n = 1; n <= LIMIT; n++) begin
         @(negedge clk);
         start = (n == lateStart);
         if (n == lateStart) startAddr = lateAddr;
         if (done === 1'b1) break;
         if (busy === 1'b1) busyLen++;
      end
      start = 1'b0;
      checkOutput("doneSeen", 32'(done), 32'd1);
      checkOutput("busyLowAtDone", 32'(busy), 32'd0);
   endtask

   // Reference: expected reads, characters, frame spacing and busy length.
   task automatic verifyBlock(input logic [11:0] addr);
      int expChars[$];
      int expGaps[$];
      logic [30:0] w;
      int code;
      for (int wi = 0; wi < BW; wi++) begin
         w = mem[(int'(addr) + wi) % 4096];
         for (int k = 0; k < 5; k++) begin
            code = int'((w >> (24 - 6 * k)) & 31'h3F);
            expChars.push_back(int'(mixTable[code]));
            expGaps.push_back((k == 0) ? FRAME + 3 : FRAME + 1);
         end
      end
      if (EOLP != 0) begin
         expChars.push_back(32'h0D);
         expGaps.push_back(FRAME + 1);
         expChars.push_back(32'h0A);
         expGaps.push_back(FRAME + 1);
      end
      checkOutput("rdCount", 32'(rdAddrQ.size()), 32'(BW));
      for (int i = 0; i < BW && i < rdAddrQ.size(); i++)
         checkOutput("rdAddr", 32'(rdAddrQ[i]), 32'((int'(addr) + i) % 4096));
      checkOutput("rxCount", 32'(rxByteQ.size()), 32'(expChars.size()));
      for (int i = 0; i < expChars.size() && i < rxByteQ.size(); i++) begin
         checkOutput("rxChar", 32'(rxByteQ[i]), 32'(32'h100 | expChars[i]));
         if (i > 0)
            checkOutput("frameGap", 32'(rxTimeQ[i] - rxTimeQ[i-1]), 32'(expGaps[i]));
      end
      checkOutput("busyLen", 32'(busyLen),
                  32'(BW * (7 + 5 * FRAME) + ((EOLP != 0) ? 2 * (FRAME + 1) : 0)));
   endtask

   task automatic applyStimulus(input logic [11:0] addr, input int lateStart,
                                input logic [11:0] lateAddr);
      startBlock(addr);
      waitDone(lateStart, lateAddr);
      verifyBlock(addr);
      @(negedge clk);
      checkOutput("donePulseWidth", 32'(done), 32'd0);
      checkOutput("idleAfterDone", 32'(busy), 32'd0);
   endtask

   task automatic fillRandom(input logic [11:0] addr);
      for (int i = 0; i < BW; i++)
         mem[(int'(addr) + i) % 4096] = 31'($urandom);
   endtask

   initial begin
      int code;
      int n0;
      logic [30:0] w;
      logic [11:0] a;

      for (int i = 0; i < 4096; i++) mem[i] = '0;

      // Reset state
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstTx", 32'(tx), 32'd1);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstMemRd", 32'(memRd), 32'd0);
      checkOutput("rstMemAddr", 32'(memAddr), 32'd0);
      resetN = 1'b1;

      // HELLO in the first word
      mem[100] = {1'b0, 6'd8, 6'd5, 6'd13, 6'd13, 6'd16};
      mem[101] = 31'($urandom);
      mem[102] = 31'($urandom);
      applyStimulus(12'd100, 0, 12'd0);

      // Translation sweep over all 64 codes, each block with both signs
      for (int blk = 0; blk < 5; blk++) begin
         for (int sgn = 0; sgn < 2; sgn++) begin
            for (int wi = 0; wi < BW; wi++) begin
               w = '0;
               w[30] = sgn[0];
               for (int k = 0; k < 5; k++) begin
                  code = blk * 15 + wi * 5 + k;
                  if (code > 63) code = 0;
                  w[29 - 6 * k -: 6] = 6'(code);
               end
               mem[200 + wi] = w;
            end
            applyStimulus(12'd200, 0, 12'd0);
         end
      end

      // Address wrap
      fillRandom(12'd4094);
      applyStimulus(12'd4094, 0, 12'd0);

      // Start while busy is ignored
      fillRandom(12'd500);
      fillRandom(12'd800);
      applyStimulus(12'd500, 50, 12'd800);

      // Reset during the data bits of the third character
      fillRandom(12'd600);
      startBlock(12'd600);
      for (int n = 0; n < LIMIT; n++) begin
         @(negedge clk);
         if (rxByteQ.size() >= 2) break;
      end
      checkOutput("reachedChar3", 32'(rxByteQ.size() >= 2), 32'd1);
      repeat (CPB / 2 + 1 + CPB + 2) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      checkOutput("abortTx", 32'(tx), 32'd1);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      n0 = rdAddrQ.size();
      repeat (60) @(negedge clk);
      checkOutput("abortNoReads", 32'(rdAddrQ.size()), 32'(n0));
      checkOutput("abortStaysIdle", 32'(busy), 32'd0);
      applyStimulus(12'd600, 0, 12'd0);

      // Back-to-back: start on the done cycle is dropped, next cycle taken
      fillRandom(12'd700);
      fillRandom(12'd900);
      startBlock(12'd700);
      waitDone(0, 12'd0);
      verifyBlock(12'd700);
      rdAddrQ.delete();
      rxByteQ.delete();
      rxTimeQ.delete();
      start     = 1'b1;
      startAddr = 12'd900;
      @(negedge clk);
      checkOutput("doneCycleStartIgnored", 32'(busy), 32'd0);
      checkOutput("donePulseWidth", 32'(done), 32'd0);
      @(negedge clk);
      start = 1'b0;
      checkOutput("nextCycleAccepted", 32'(busy), 32'd1);
      busyLen = 1;
      waitDone(0, 12'd0);
      verifyBlock(12'd900);

      // Random blocks
      for (int r = 0; r < 4; r++) begin
         a = 12'($urandom);
         fillRandom(a);
         applyStimulus(a, 0, 12'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
